// File: rtl/pll_reset_seq.sv
// Staged reset sequencer for the PLL output clock domain: filters the PLL lock,
// holds reset through a settling window, then releases core and peripheral resets in order.
module pll_reset_seq #(
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_FILTER = 16,
   parameter int HOLDOFF     = 1024,
   parameter int STAGE_GAP   = 16,
   parameter int CNT_W       = 8
) (
   input  logic             clki,
   input  logic             rst_n,
   input  logic             pll_lock,
   input  logic             soft_rst_req,
   output logic             sys_rst_n,
   output logic             periph_rst_n,
   output logic             ready,
   output logic [CNT_W-1:0] lock_loss_cnt
);

   localparam int FILT_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
   localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam int GAP_W  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

   localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
   localparam logic [CNT_W-1:0]  LOSS_MAX  = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      ST_WAIT_LOCK,
      ST_HOLDOFF,
      ST_SYS_UP,
      ST_RUN,
      ST_LOST
   } state_t;

   state_t            state_reg, state_next;
   logic [SYNC_STAGES-1:0] sync_reg;
   logic [FILT_W-1:0] filt_reg, filt_next;
   logic [HOLD_W-1:0] hold_reg, hold_next;
   logic [GAP_W-1:0]  gap_reg, gap_next;
   logic [CNT_W-1:0]  loss_reg, loss_next;
   logic              sys_rst_n_reg, periph_rst_n_reg, ready_reg;
   logic              lock_s;

   always_ff @(posedge clki or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], pll_lock};
      end
   end

   assign lock_s = sync_reg[SYNC_STAGES-1];

   always_ff @(posedge clki or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= ST_WAIT_LOCK;
         filt_reg         <= '0;
         hold_reg         <= '0;
         gap_reg          <= '0;
         loss_reg         <= '0;
         sys_rst_n_reg    <= 1'b0;
         periph_rst_n_reg <= 1'b0;
         ready_reg        <= 1'b0;
      end else begin
         state_reg        <= state_next;
         filt_reg         <= filt_next;
         hold_reg         <= hold_next;
         gap_reg          <= gap_next;
         loss_reg         <= loss_next;
         // Outputs follow the state being entered so they move on the transition edge.
         sys_rst_n_reg    <= (state_next == ST_SYS_UP) || (state_next == ST_RUN);
         periph_rst_n_reg <= (state_next == ST_RUN);
         ready_reg        <= (state_next == ST_RUN);
      end
   end

   always_comb begin
      state_next = state_reg;
      filt_next  = filt_reg;
      hold_next  = hold_reg;
      gap_next   = gap_reg;
      loss_next  = loss_reg;

      if (soft_rst_req) begin
         state_next = ST_WAIT_LOCK;
         filt_next  = '0;
         hold_next  = '0;
         gap_next   = '0;
      end else begin
         case (state_reg)
            ST_WAIT_LOCK: begin
               if (!lock_s) begin
                  filt_next = '0;
               end else if (filt_reg == FILT_LAST) begin
                  state_next = ST_HOLDOFF;
                  filt_next  = '0;
                  hold_next  = '0;
               end else begin
                  filt_next = filt_reg + 1'b1;
               end
            end
            ST_HOLDOFF: begin
               if (!lock_s) begin
                  state_next = ST_WAIT_LOCK;
                  filt_next  = '0;
                  hold_next  = '0;
               end else if (hold_reg == HOLD_LAST) begin
                  state_next = ST_SYS_UP;
                  hold_next  = '0;
                  gap_next   = '0;
               end else begin
                  hold_next = hold_reg + 1'b1;
               end
            end
            ST_SYS_UP: begin
               if (!lock_s) begin
                  state_next = ST_LOST;
                  gap_next   = '0;
               end else if (gap_reg == GAP_LAST) begin
                  state_next = ST_RUN;
                  gap_next   = '0;
               end else begin
                  gap_next = gap_reg + 1'b1;
               end
            end
            ST_RUN: begin
               if (!lock_s) begin
                  state_next = ST_LOST;
                  if (loss_reg != LOSS_MAX) begin
                     loss_next = loss_reg + 1'b1;
                  end
               end
            end
            ST_LOST: begin
               state_next = ST_WAIT_LOCK;
               filt_next  = '0;
            end
            default: begin
               state_next = ST_WAIT_LOCK;
               filt_next  = '0;
               hold_next  = '0;
               gap_next   = '0;
            end
         endcase
      end
   end

   assign sys_rst_n     = sys_rst_n_reg;
   assign periph_rst_n  = periph_rst_n_reg;
   assign ready         = ready_reg;
   assign lock_loss_cnt = loss_reg;

endmodule
